sha256_msg_pad: RTL and testbench

Upstream stage of the mining datapath's SHA-256 compression core. It accepts an arbitrary-length byte message over a valid/ready stream and applies SHA-256 padding: a 0x80 marker byte, zero fill, and a 64-bit big-endian bit-length field. It emits a sequence of 512-bit chunks over a second valid/ready handshake, in the big-endian layout the compression core expects, with the final chunk flagged so the controller knows when to latch the hash.

---
 rtl/sha256_pkg.sv | 40 ++++
 rtl/sha256_msg_pad.sv | 137 +++++++++++++
 tb/tb_sha256_msg_pad.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, block/field widths,
// initial hash values and the round-constant table.
package sha256_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_PAD   = 2'd1,
    S_EXTRA = 2'd2,
    S_EMIT  = 2'd3
  } pad_state_e;

  localparam int         CHUNK_W     = 512;
  localparam int         LEN_FIELD_W = 64;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: collects a byte stream into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit big-endian bit length, and emits
// the blocks to the compression core. Byte 0 of a block sits at [511:504].
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; once chunk_valid rises it stays high, with chunk and
// chunk_last unchanged, until chunk_ready completes the transfer.
module sha256_msg_pad
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               chunk_valid,
  input  logic               chunk_ready,
  output logic [CHUNK_W-1:0] chunk,
  output logic               chunk_last,
  output logic               busy,
  output pad_state_e         dbg_state
);

  pad_state_e         state_q;
  logic [CHUNK_W-1:0] blk_q;
  logic [6:0]         idx_q;
  logic [LEN_W-1:0]   bitlen_q;
  logic               pad_pending_q;
  logic               extra_pending_q;
  logic               chunk_last_q;

  logic [CHUNK_W-1:0]     fill_d;
  logic [CHUNK_W-1:0]     pad_d;
  logic [LEN_FIELD_W-1:0] len_field;

  assign len_field = LEN_FIELD_W'(bitlen_q);

  // Block images for a byte write at idx and for the padding step at idx.
  always_comb begin
    fill_d = blk_q;
    pad_d  = blk_q;
    for (int b = 0; b < 64; b++) begin
      if (7'(b) == idx_q) begin
        fill_d[511-8*b -: 8] = in_data;
        pad_d[511-8*b -: 8]  = PAD_BYTE;
      end else if (7'(b) > idx_q) begin
        pad_d[511-8*b -: 8]  = 8'h00;
      end
    end
    // Length only fits when the marker landed at byte 55 or earlier.
    if (idx_q <= 7'd55) begin
      pad_d[LEN_FIELD_W-1:0] = len_field;
    end
  end

  // Padder FSM and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= S_FILL;
      blk_q           <= '0;
      idx_q           <= '0;
      bitlen_q        <= '0;
      pad_pending_q   <= 1'b0;
      extra_pending_q <= 1'b0;
      chunk_last_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (in_valid) begin
            blk_q    <= fill_d;
            idx_q    <= idx_q + 7'd1;
            bitlen_q <= bitlen_q + LEN_W'(8);
            if (idx_q == 7'd63) begin
              state_q       <= S_EMIT;
              chunk_last_q  <= 1'b0;
              pad_pending_q <= in_last;
            end else if (in_last) begin
              state_q <= S_PAD;
            end
          end
        end
        S_PAD: begin
          blk_q   <= pad_d;
          state_q <= S_EMIT;
          if (idx_q <= 7'd55) begin
            chunk_last_q <= 1'b1;
          end else begin
            chunk_last_q    <= 1'b0;
            extra_pending_q <= 1'b1;
          end
        end
        S_EXTRA: begin
          blk_q        <= {{(CHUNK_W-LEN_FIELD_W){1'b0}}, len_field};
          chunk_last_q <= 1'b1;
          state_q      <= S_EMIT;
        end
        S_EMIT: begin
          if (chunk_ready) begin
            if (chunk_last_q) begin
              blk_q           <= '0;
              idx_q           <= '0;
              bitlen_q        <= '0;
              pad_pending_q   <= 1'b0;
              extra_pending_q <= 1'b0;
              chunk_last_q    <= 1'b0;
              state_q         <= S_FILL;
            end else if (pad_pending_q) begin
              // Message filled whole blocks exactly: marker goes at byte 0.
              idx_q         <= '0;
              pad_pending_q <= 1'b0;
              state_q       <= S_PAD;
            end else if (extra_pending_q) begin
              extra_pending_q <= 1'b0;
              state_q         <= S_EXTRA;
            end else begin
              idx_q   <= '0;
              blk_q   <= '0;
              state_q <= S_FILL;
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign in_ready    = reset && (state_q == S_FILL);
  assign chunk_valid = (state_q == S_EMIT);
  assign chunk       = blk_q;
  assign chunk_last  = chunk_last_q;
  assign busy        = (state_q != S_FILL) || (idx_q != 7'd0);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Directed bench for sha256_msg_pad: expected blocks go into a queue as
// each message is sent; a monitor pops and compares on every handshake.
module tb_sha256_msg_pad;
  import sha256_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic         chunk_valid;
  logic         chunk_ready;
  logic [511:0] chunk;
  logic         chunk_last;
  logic         busy;
  pad_state_e   dbg_state;

  logic [512:0] exp_q[$];
  logic [7:0]   msg [0:63];
  int           checks = 0;
  int           errors = 0;
  int           hs_count = 0;

  sha256_msg_pad #(.LEN_W(64)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready),
    .chunk_valid(chunk_valid), .chunk_ready(chunk_ready),
    .chunk(chunk), .chunk_last(chunk_last),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clock = ~clock;

  // Monitor: compare every completed output transfer against the queue.
  always @(negedge clock) begin
    logic [512:0] e;
    if (reset && chunk_valid && chunk_ready) begin
      hs_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL chunk_unexpected got last=%0b data=%h", chunk_last, chunk);
      end else begin
        e = exp_q.pop_front();
        if ({chunk_last, chunk} !== e) begin
          errors++;
          $display("FAIL chunk got last=%0b data=%h required last=%0b data=%h",
                   chunk_last, chunk, e[512], e[511:0]);
        end
      end
    end
  end

  task automatic check1(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0b required %0b", name, got, req);
    end
  endtask

  // Driver: present one byte, hold until accepted (bounded).
  task automatic send_byte(input logic [7:0] d, input logic l);
    int  n = 0;
    logic acc;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock); #1;
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready=0 required 1");
    end
  endtask

  task automatic send_msg(input int n);
    for (int i = 0; i < n; i++) send_byte(msg[i], (i == n - 1));
  endtask

  task automatic load_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  // Wait until all expected blocks were seen and the block is idle.
  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clock); n++;
    end
    @(posedge clock); #1;
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d required 0", exp_q.size());
    end
  endtask

  localparam logic [512:0] EXP_ABC = {1'b1, 32'h61626380, 416'b0, 64'h18};

  initial begin
    logic [511:0] v;
    logic [511:0] first;
    int           hs0;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    chunk_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_chunk_valid", chunk_valid, 1'b0);
    check1("rst_chunk_last", chunk_last, 1'b0);
    check1("rst_busy", busy, 1'b0);
    checks++;
    if (chunk !== 512'b0) begin
      errors++; $display("FAIL rst_chunk got %h required 0", chunk);
    end
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check1("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;

    // "abc" with latency: pad cycle, then chunk_valid.
    load_abc();
    exp_q.push_back(EXP_ABC);
    send_msg(3);
    @(negedge clock);
    check1("abc_pad_cycle_valid", chunk_valid, 1'b0);
    check1("abc_pad_cycle_in_ready", in_ready, 1'b0);
    @(negedge clock);
    check1("abc_emit_valid", chunk_valid, 1'b1);
    wait_drain();

    // 55 zero bytes: marker at byte 55, length 440.
    for (int i = 0; i < 55; i++) msg[i] = 8'h00;
    exp_q.push_back({1'b1, 440'b0, 8'h80, 64'h1B8});
    send_msg(55);
    wait_drain();

    // 56 x FF: marker block, then length-only block.
    for (int i = 0; i < 56; i++) msg[i] = 8'hFF;
    exp_q.push_back({1'b0, {56{8'hFF}}, 8'h80, 56'b0});
    exp_q.push_back({1'b1, 448'b0, 64'h1C0});
    send_msg(56);
    wait_drain();

    // 64 bytes 00..3F: verbatim block, then marker+length block.
    for (int i = 0; i < 64; i++) begin
      msg[i] = 8'(i);
      v[511-8*i -: 8] = 8'(i);
    end
    exp_q.push_back({1'b0, v});
    exp_q.push_back({1'b1, 8'h80, 440'b0, 64'h200});
    send_msg(64);
    @(negedge clock);
    check1("full_block_valid_next_cycle", chunk_valid, 1'b1);
    wait_drain();

    // Backpressure during "abc".
    hs0 = hs_count;
    chunk_ready = 1'b0;
    load_abc();
    exp_q.push_back(EXP_ABC);
    send_msg(3);
    @(negedge clock);
    @(negedge clock);
    first = chunk;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check1("bp_valid_held", chunk_valid, 1'b1);
      check1("bp_last_held", chunk_last, 1'b1);
      check1("bp_in_ready_low", in_ready, 1'b0);
      checks++;
      if (chunk !== first) begin
        errors++; $display("FAIL bp_chunk_stable got %h required %h", chunk, first);
      end
    end
    @(posedge clock); #1 chunk_ready = 1'b1;
    wait_drain();
    checks++;
    if (hs_count != hs0 + 1) begin
      errors++; $display("FAIL bp_handshakes got %0d required 1", hs_count - hs0);
    end

    // Reset mid-message, then "abc" must match the first result exactly.
    for (int i = 0; i < 30; i++) send_byte(8'(i + 8'h40), 1'b0);
    @(negedge clock);
    check1("partial_busy", busy, 1'b1);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check1("midrst_in_ready", in_ready, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_chunk_valid", chunk_valid, 1'b0);
    @(posedge clock); #1 reset = 1'b1;
    load_abc();
    exp_q.push_back(EXP_ABC);
    send_msg(3);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
